// File: rtl/ntt_job_ctrl.sv
// Job sequencer for one NTT job: stream coefficients into the coefficient RAM,
// hand both RAM ports to the core while it runs, then stream the results back out.
module ntt_job_ctrl #(
  parameter int WIDTH   = 24,
  parameter int N       = 256,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  // job control
  input  logic              job_start,
  input  logic              job_abort,
  output logic              job_busy,
  output logic              job_done,
  output logic              err,
  // load stream
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  // unload stream
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_last,
  // core handshake
  output logic              ntt_start,
  input  logic              ntt_done,
  // core side of the RAM ports
  input  logic [ADDR_W-1:0] core_addr_a,
  input  logic [ADDR_W-1:0] core_addr_b,
  input  logic              core_we_a,
  input  logic              core_we_b,
  input  logic [WIDTH-1:0]  core_wdata_a,
  input  logic [WIDTH-1:0]  core_wdata_b,
  output logic [WIDTH-1:0]  core_rdata_a,
  output logic [WIDTH-1:0]  core_rdata_b,
  // RAM ports
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic              ram_we_a,
  output logic              ram_we_b,
  output logic [WIDTH-1:0]  ram_wdata_a,
  output logic [WIDTH-1:0]  ram_wdata_b,
  input  logic [WIDTH-1:0]  ram_rdata_a,
  input  logic [WIDTH-1:0]  ram_rdata_b,
  // debug view of the sequencer state
  output logic [2:0]        state_dbg
);

  // Streams: a word transfers on a rising clk edge where valid and ready are
  // both high. in_ready depends on state only; out_valid/out_data/out_last are
  // registered and hold steady until out_ready is seen.

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [15:0]      TO_LAST  = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RUN     = 3'd2,
    RUN_REL = 3'd3,
    UL_RD   = 3'd4,
    UL_WAIT = 3'd5,
    UL_OUT  = 3'd6
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      to_cnt;
  logic             core_owns;

  assign core_owns    = (state == RUN) || (state == RUN_REL);
  assign in_ready     = (state == LOAD);
  assign job_busy     = (state != IDLE);
  assign state_dbg    = state;
  assign core_rdata_a = ram_rdata_a;
  assign core_rdata_b = ram_rdata_b;

  // The core only reaches the RAM while it owns it; elsewhere its writes are dropped.
  always_comb begin
    ram_addr_a  = '0;
    ram_addr_b  = '0;
    ram_we_a    = 1'b0;
    ram_we_b    = 1'b0;
    ram_wdata_a = '0;
    ram_wdata_b = '0;
    unique case (state)
      RUN, RUN_REL: begin
        ram_addr_a  = core_addr_a;
        ram_addr_b  = core_addr_b;
        ram_we_a    = core_we_a;
        ram_we_b    = core_we_b;
        ram_wdata_a = core_wdata_a;
        ram_wdata_b = core_wdata_b;
      end
      LOAD: begin
        ram_addr_a  = cnt[ADDR_W-1:0];
        ram_we_a    = in_valid;
        ram_wdata_a = in_data;
      end
      UL_RD, UL_WAIT: begin
        ram_addr_a  = cnt[ADDR_W-1:0];
      end
      default: begin
        ram_addr_a  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      to_cnt    <= '0;
      err       <= 1'b0;
      ntt_start <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      job_done  <= 1'b0;
    end else begin
      job_done <= 1'b0;
      if (job_abort) begin
        // Dropping ntt_start is enough for the core to fall back to its own idle.
        state     <= IDLE;
        cnt       <= '0;
        to_cnt    <= '0;
        ntt_start <= 1'b0;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (job_start) begin
              state <= LOAD;
              cnt   <= '0;
              err   <= 1'b0;
            end
          end
          LOAD: begin
            if (in_valid) begin
              if (cnt == CNT_LAST) begin
                state     <= RUN;
                cnt       <= '0;
                to_cnt    <= '0;
                ntt_start <= 1'b1;
              end else begin
                cnt <= cnt + CNT_ONE;
              end
            end
          end
          RUN: begin
            // A done arriving on the last allowed cycle still counts as success.
            if (ntt_done) begin
              state     <= RUN_REL;
              ntt_start <= 1'b0;
            end else if (to_cnt == TO_LAST) begin
              state     <= IDLE;
              err       <= 1'b1;
              ntt_start <= 1'b0;
            end else begin
              to_cnt <= to_cnt + 16'd1;
            end
          end
          RUN_REL: begin
            if (!ntt_done) begin
              state <= UL_RD;
              cnt   <= '0;
            end
          end
          UL_RD: begin
            state <= UL_WAIT;
          end
          UL_WAIT: begin
            out_data  <= ram_rdata_a;
            out_valid <= 1'b1;
            out_last  <= (cnt == CNT_LAST);
            state     <= UL_OUT;
          end
          UL_OUT: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              if (cnt == CNT_LAST) begin
                state    <= IDLE;
                cnt      <= '0;
                job_done <= 1'b1;
              end else begin
                state <= UL_RD;
                cnt   <= cnt + CNT_ONE;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ntt_job_ctrl.sv
// Bench for ntt_job_ctrl: behavioural dual-port RAM, a small scripted core stub,
// directed jobs covering load, run, timeout, abort and back-pressured unload.
module tb_ntt_job_ctrl;

  localparam int WIDTH   = 24;
  localparam int N       = 256;
  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 300;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              job_start = 1'b0, job_abort = 1'b0;
  logic              job_busy, job_done, err;
  logic              in_valid = 1'b0, in_ready;
  logic [WIDTH-1:0]  in_data = '0;
  logic              out_valid, out_ready = 1'b1, out_last;
  logic [WIDTH-1:0]  out_data;
  logic              ntt_start, ntt_done;
  logic [ADDR_W-1:0] core_addr_a, core_addr_b, ram_addr_a, ram_addr_b;
  logic              core_we_a, core_we_b, ram_we_a, ram_we_b;
  logic [WIDTH-1:0]  core_wdata_a, core_wdata_b, core_rdata_a, core_rdata_b;
  logic [WIDTH-1:0]  ram_wdata_a, ram_wdata_b, ram_rdata_a, ram_rdata_b;
  logic [2:0]        state_dbg;

  ntt_job_ctrl #(.WIDTH(WIDTH), .N(N), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .job_start(job_start), .job_abort(job_abort), .job_busy(job_busy),
    .job_done(job_done), .err(err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .ntt_start(ntt_start), .ntt_done(ntt_done),
    .core_addr_a(core_addr_a), .core_addr_b(core_addr_b),
    .core_we_a(core_we_a), .core_we_b(core_we_b),
    .core_wdata_a(core_wdata_a), .core_wdata_b(core_wdata_b),
    .core_rdata_a(core_rdata_a), .core_rdata_b(core_rdata_b),
    .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
    .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
    .ram_wdata_a(ram_wdata_a), .ram_wdata_b(ram_wdata_b),
    .ram_rdata_a(ram_rdata_a), .ram_rdata_b(ram_rdata_b),
    .state_dbg(state_dbg)
  );

  // ---------------- RAM model: 1-cycle read latency ----------------
  logic [WIDTH-1:0] mem [N];
  always_ff @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_wdata_a;
    if (ram_we_b) mem[ram_addr_b] <= ram_wdata_b;
    ram_rdata_a <= mem[ram_addr_a];
    ram_rdata_b <= mem[ram_addr_b];
  end

  // ---------------- core stub ----------------
  // mode 0: done 20 cycles after start, no writes
  // mode 1: x[k] += 1000 via read on A / write on B, then done
  // mode 2: never done
  // Outside RUN/RUN_REL it drives junk writes that the controller must drop.
  int         core_mode = 0;
  logic [8:0] s_cnt;
  logic       done_r, running, junk;
  assign ntt_done = done_r;
  assign running  = ntt_start && !done_r;
  assign junk     = !job_busy || in_ready || out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_cnt  <= '0;
      done_r <= 1'b0;
    end else if (!ntt_start) begin
      s_cnt  <= '0;
      done_r <= 1'b0;
    end else if (!done_r) begin
      if (core_mode == 0) begin
        if (s_cnt == 9'd19) done_r <= 1'b1;
        else s_cnt <= s_cnt + 9'd1;
      end else if (core_mode == 1) begin
        if (s_cnt == 9'd256) done_r <= 1'b1;
        else s_cnt <= s_cnt + 9'd1;
      end
    end
  end

  always_comb begin
    core_addr_a  = '0;
    core_addr_b  = '0;
    core_we_a    = 1'b0;
    core_we_b    = 1'b0;
    core_wdata_a = '0;
    core_wdata_b = '0;
    if (running) begin
      if (core_mode == 1) begin
        core_addr_a  = s_cnt[7:0];
        core_we_b    = (s_cnt != 9'd0);
        core_addr_b  = 8'(s_cnt - 9'd1);
        core_wdata_b = core_rdata_a + 24'd1000;
      end
    end else if (junk) begin
      core_we_a    = 1'b1;
      core_we_b    = 1'b1;
      core_addr_a  = 8'd5;
      core_addr_b  = 8'd9;
      core_wdata_a = 24'hBADBAD;
      core_wdata_b = 24'hBADBAD;
    end
  end

  // ---------------- scoreboard state ----------------
  logic [WIDTH-1:0] src [N];
  logic [WIDTH-1:0] exp_q [$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-job monitor counters; cleared when a start is accepted.
  int lw_cnt = 0, lw_bad = 0, done_cnt = 0, gate_bad = 0;
  always @(negedge clk) begin
    if (rst_n && job_start && !job_busy && !job_abort) begin
      lw_cnt = 0; lw_bad = 0; done_cnt = 0; gate_bad = 0;
    end else begin
      if (in_ready && ram_we_a) begin
        if (!in_valid || lw_cnt >= N) lw_bad++;
        else if (ram_addr_a != lw_cnt[7:0] || ram_wdata_a != src[lw_cnt]) lw_bad++;
        lw_cnt++;
      end
      if (job_done) done_cnt++;
      if (ram_we_a && (!job_busy || out_valid)) gate_bad++;
      if (ram_we_b && (!job_busy || in_ready || out_valid)) gate_bad++;
      if (core_rdata_a !== ram_rdata_a || core_rdata_b !== ram_rdata_b) gate_bad++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_job();
    job_start = 1'b1;
    tick();
    job_start = 1'b0;
  endtask

  task automatic load(input int n, input bit rnd);
    int i = 0;
    int cyc = 0;
    bit hs;
    while (i < n && cyc < 3000) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = src[i];
      hs = in_valid && in_ready;
      tick();
      cyc++;
      if (hs) i++;
    end
    in_valid = 1'b0;
    check("load_accepts", i, n);
  endtask

  task automatic unload(input string name, input int stall_idx);
    int got = 0;
    int cyc = 0;
    out_ready = 1'b1;
    while (got < N && cyc < 5000) begin
      if (out_valid) begin
        if (got == stall_idx) begin
          out_ready = 1'b0;
          for (int h = 0; h < 5; h++) begin
            tick();
            check({name, "_hold_data"}, out_data, exp_q[0]);
            check({name, "_hold_valid"}, out_valid, 1);
            check({name, "_hold_last"}, out_last, 0);
          end
          out_ready = 1'b1;
        end
        check({name, "_data"}, out_data, exp_q.pop_front());
        check({name, "_last"}, out_last, (got == N - 1) ? 1 : 0);
        got++;
      end
      tick();
      cyc++;
    end
    check({name, "_words"}, got, N);
  endtask

  task automatic do_job(input string name, input int mode, input int pat, input bit rnd,
                        input int stall_idx);
    core_mode = mode;
    for (int k = 0; k < N; k++) begin
      src[k] = (pat == 0) ? 24'(k) : 24'(k * 12345 + 77);
      exp_q.push_back((mode == 1) ? src[k] + 24'd1000 : src[k]);
    end
    start_job();
    load(N, rnd);
    if (!rnd) begin
      // start while busy must be ignored
      job_start = 1'b1;
      tick();
      job_start = 1'b0;
      check({name, "_busy_run"}, job_busy, 1);
    end
    unload(name, stall_idx);
    tick();
    tick();
    check({name, "_load_writes"}, lw_cnt, N);
    check({name, "_load_bad"}, lw_bad, 0);
    check({name, "_done_pulses"}, done_cnt, 1);
    check({name, "_err"}, err, 0);
    check({name, "_gate_bad"}, gate_bad, 0);
    check({name, "_idle"}, job_busy, 0);
    check({name, "_q_empty"}, exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int run_cyc;
    int cyc;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", job_busy, 0);
    check("rst_done", job_done, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_ntt_start", ntt_start, 0);
    check("rst_we_a", ram_we_a, 0);
    check("rst_we_b", ram_we_b, 0);
    check("rst_state", state_dbg, 0);
    rst_n = 1'b1;
    tick();
    check("idle_we_b", ram_we_b, 0);

    // Job 1: ramp data, stub done after 20 cycles, stall on word 7.
    do_job("j1", 0, 0, 1'b0, 7);

    // Job 2: hashed data, random in_valid gaps.
    do_job("j2", 0, 1, 1'b1, -1);

    // Job 3: core never finishes -> timeout.
    core_mode = 2;
    for (int k = 0; k < N; k++) src[k] = 24'(k);
    start_job();
    load(N, 1'b0);
    run_cyc = 0;
    cyc = 0;
    while (!err && cyc < 1000) begin
      if (ntt_start) run_cyc++;
      tick();
      cyc++;
    end
    check("to_run_cycles", run_cyc, TIMEOUT);
    check("to_err", err, 1);
    check("to_ntt_start", ntt_start, 0);
    check("to_busy", job_busy, 0);
    tick();
    tick();
    check("to_no_done", done_cnt, 0);
    check("to_out_valid", out_valid, 0);
    check("to_err_sticky", err, 1);

    // Job 4: abort during load at word 100, then a full job with the transforming stub.
    core_mode = 1;
    start_job();
    check("ab_err_cleared", err, 0);
    load(100, 1'b0);
    check("ab_partial_writes", lw_cnt, 100);
    job_abort = 1'b1;
    tick();
    job_abort = 1'b0;
    check("ab_busy", job_busy, 0);
    check("ab_in_ready", in_ready, 0);
    check("ab_state", state_dbg, 0);
    check("ab_ntt_start", ntt_start, 0);
    do_job("j4", 1, 0, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

endmodule
